// File: rtl/mem_stage_ctrl_if.sv
// Memory-stage bundle: EX/MEM slot inputs, data-memory handshake and MEM/WB outputs.
// master = the memory-stage sequencer, slave = the surrounding pipeline and memory.
interface mem_stage_ctrl_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic              in_valid;
   logic [3:0]        mem_signals;
   logic [2:0]        wb_signals;
   logic [DATA_W-1:0] alu_result;
   logic [DATA_W-1:0] rsrc_val;
   logic [DATA_W-1:0] rdst_val;
   logic [2:0]        rd_addr;
   logic              flush;
   logic              stall;
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_ack;
   logic [DATA_W-1:0] dm_rdata;
   logic              wb_valid;
   logic [2:0]        wb_signals_out;
   logic [DATA_W-1:0] wb_mem_data;
   logic [DATA_W-1:0] wb_alu_data;
   logic [2:0]        wb_rd;
   logic              mem_err;

   modport master (
      input  in_valid, mem_signals, wb_signals, alu_result, rsrc_val, rdst_val,
             rd_addr, flush, dm_ack, dm_rdata,
      output stall, dm_req, dm_we, dm_addr, dm_wdata, wb_valid, wb_signals_out,
             wb_mem_data, wb_alu_data, wb_rd, mem_err
   );

   modport slave (
      output in_valid, mem_signals, wb_signals, alu_result, rsrc_val, rdst_val,
             rd_addr, flush, dm_ack, dm_rdata,
      input  stall, dm_req, dm_we, dm_addr, dm_wdata, wb_valid, wb_signals_out,
             wb_mem_data, wb_alu_data, wb_rd, mem_err
   );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage sequencer: runs one handshaked data-memory transaction per load/store,
// stalls upstream while it is outstanding, and passes other instructions to MEM/WB in 1 cycle.
module mem_stage_ctrl #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 16,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   mem_stage_ctrl_if.master bus
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

   state_t            state, state_nxt;
   logic [7:0]        cnt, cnt_nxt;
   logic              kill, kill_nxt;
   logic [2:0]        lat_sig, lat_sig_nxt;
   logic [2:0]        lat_rd, lat_rd_nxt;
   logic [DATA_W-1:0] lat_alu, lat_alu_nxt;
   logic              lat_load, lat_load_nxt;

   logic              req_q, req_nxt;
   logic              we_q, we_nxt;
   logic [ADDR_W-1:0] addr_q, addr_nxt;
   logic [DATA_W-1:0] wdata_q, wdata_nxt;
   logic              wbv_q, wbv_nxt;
   logic [2:0]        wsig_q, wsig_nxt;
   logic [DATA_W-1:0] mdata_q, mdata_nxt;
   logic [DATA_W-1:0] walu_q, walu_nxt;
   logic [2:0]        wrd_q, wrd_nxt;
   logic              err_q, err_nxt;

   logic              is_rd, is_wr, live, memop, illegal, passthru, timeout;
   logic [DATA_W-1:0] addr_src, data_src;

   assign is_rd    = bus.mem_signals[3];
   assign is_wr    = bus.mem_signals[2];
   assign live     = bus.in_valid & ~bus.flush;
   assign memop    = live & (is_rd | is_wr);
   assign illegal  = live & is_rd & is_wr;
   assign passthru = live & ~is_rd & ~is_wr;
   assign timeout  = (cnt == TO_LAST);
   assign addr_src = bus.mem_signals[1] ? bus.rdst_val : bus.rsrc_val;
   assign data_src = bus.mem_signals[0] ? bus.alu_result : bus.rsrc_val;

   // Stall is gated by reset so it drops the moment rst_n falls.
   assign bus.stall = rst_n & ((state == BUSY) | ((state == IDLE) & memop & ~illegal));

   assign bus.dm_req         = req_q;
   assign bus.dm_we          = we_q;
   assign bus.dm_addr        = addr_q;
   assign bus.dm_wdata       = wdata_q;
   assign bus.wb_valid       = wbv_q;
   assign bus.wb_signals_out = wsig_q;
   assign bus.wb_mem_data    = mdata_q;
   assign bus.wb_alu_data    = walu_q;
   assign bus.wb_rd          = wrd_q;
   assign bus.mem_err        = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         kill     <= 1'b0;
         lat_sig  <= '0;
         lat_rd   <= '0;
         lat_alu  <= '0;
         lat_load <= 1'b0;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wbv_q    <= 1'b0;
         wsig_q   <= '0;
         mdata_q  <= '0;
         walu_q   <= '0;
         wrd_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         kill     <= kill_nxt;
         lat_sig  <= lat_sig_nxt;
         lat_rd   <= lat_rd_nxt;
         lat_alu  <= lat_alu_nxt;
         lat_load <= lat_load_nxt;
         req_q    <= req_nxt;
         we_q     <= we_nxt;
         addr_q   <= addr_nxt;
         wdata_q  <= wdata_nxt;
         wbv_q    <= wbv_nxt;
         wsig_q   <= wsig_nxt;
         mdata_q  <= mdata_nxt;
         walu_q   <= walu_nxt;
         wrd_q    <= wrd_nxt;
         err_q    <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (memop && !illegal) state_nxt = BUSY;
         BUSY:    if (bus.dm_ack || timeout) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cnt_nxt      = cnt;
      kill_nxt     = kill;
      lat_sig_nxt  = lat_sig;
      lat_rd_nxt   = lat_rd;
      lat_alu_nxt  = lat_alu;
      lat_load_nxt = lat_load;
      req_nxt      = req_q;
      we_nxt       = we_q;
      addr_nxt     = addr_q;
      wdata_nxt    = wdata_q;
      wbv_nxt      = 1'b0;
      err_nxt      = 1'b0;
      wsig_nxt     = wsig_q;
      mdata_nxt    = mdata_q;
      walu_nxt     = walu_q;
      wrd_nxt      = wrd_q;
      case (state)
         // DONE still presents the retiring mem op, so only a pass-through is honoured there.
         IDLE, DONE: begin
            if (passthru) begin
               wbv_nxt  = 1'b1;
               wsig_nxt = bus.wb_signals;
               walu_nxt = bus.alu_result;
               wrd_nxt  = bus.rd_addr;
            end else if (state == IDLE && illegal) begin
               err_nxt  = 1'b1;
               wbv_nxt  = 1'b1;
               wsig_nxt = {1'b0, bus.wb_signals[1:0]};
               walu_nxt = bus.alu_result;
               wrd_nxt  = bus.rd_addr;
            end else if (state == IDLE && memop) begin
               req_nxt      = 1'b1;
               we_nxt       = is_wr;
               addr_nxt     = addr_src[ADDR_W-1:0];
               wdata_nxt    = data_src;
               lat_sig_nxt  = bus.wb_signals;
               lat_rd_nxt   = bus.rd_addr;
               lat_alu_nxt  = bus.alu_result;
               lat_load_nxt = is_rd;
               cnt_nxt      = '0;
               kill_nxt     = 1'b0;
            end
         end
         BUSY: begin
            cnt_nxt  = cnt + 8'd1;
            kill_nxt = kill | bus.flush;
            if (bus.dm_ack) begin
               req_nxt = 1'b0;
               // A flush seen at any point of the transaction discards its result.
               if (!(kill || bus.flush)) begin
                  wbv_nxt  = 1'b1;
                  wsig_nxt = lat_sig;
                  walu_nxt = lat_alu;
                  wrd_nxt  = lat_rd;
                  if (lat_load) mdata_nxt = bus.dm_rdata;
               end
            end else if (timeout) begin
               req_nxt = 1'b0;
               err_nxt = 1'b1;
            end
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: transaction-level model checked every cycle,
// plus hand-computed literal checks for each scenario.
module tb_mem_stage_ctrl;
   localparam int DW = 16;
   localparam int AW = 16;
   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   vecs = 0;
   int   errs = 0;
   bit   chk_en = 1'b0;

   mem_stage_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   mem_stage_ctrl #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Model: an outstanding request with its age in bus cycles, and the last retired slot.
   bit          m_busy = 0, m_done = 0, m_kill = 0, m_load = 0;
   int          m_age = 0;
   logic [2:0]  m_sig = '0, m_rd = '0;
   logic [15:0] m_alu = '0;
   logic        m_req = 0, m_we = 0;
   logic [15:0] m_addr = '0, m_wdata = '0;
   logic        e_wbv = 0, e_err = 0;
   logic [2:0]  e_sig = '0, e_rd = '0;
   logic [15:0] e_alu = '0, e_mdata = '0;
   logic        e_stall;

   assign e_stall = rst_n && (m_busy || (!m_done && bus.in_valid && !bus.flush &&
                    (bus.mem_signals[3] ^ bus.mem_signals[2])));

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 0; m_done <= 0; m_kill <= 0; m_load <= 0; m_age <= 0;
         m_sig <= '0; m_rd <= '0; m_alu <= '0;
         m_req <= 0; m_we <= 0; m_addr <= '0; m_wdata <= '0;
         e_wbv <= 0; e_err <= 0; e_sig <= '0; e_rd <= '0; e_alu <= '0; e_mdata <= '0;
      end else begin
         e_wbv <= 0;
         e_err <= 0;
         if (m_busy) begin
            m_age  <= m_age + 1;
            m_kill <= m_kill | bus.flush;
            if (bus.dm_ack) begin
               m_busy <= 0; m_done <= 1; m_req <= 0;
               if (!(m_kill || bus.flush)) begin
                  e_wbv <= 1; e_sig <= m_sig; e_alu <= m_alu; e_rd <= m_rd;
                  if (m_load) e_mdata <= bus.dm_rdata;
               end
            end else if (m_age == TO) begin
               m_busy <= 0; m_done <= 1; m_req <= 0; e_err <= 1;
            end
         end else begin
            m_done <= 0;
            if (bus.in_valid && !bus.flush) begin
               if (!bus.mem_signals[3] && !bus.mem_signals[2]) begin
                  e_wbv <= 1; e_sig <= bus.wb_signals; e_alu <= bus.alu_result; e_rd <= bus.rd_addr;
               end else if (!m_done && bus.mem_signals[3] && bus.mem_signals[2]) begin
                  e_err <= 1; e_wbv <= 1; e_sig <= {1'b0, bus.wb_signals[1:0]};
                  e_alu <= bus.alu_result; e_rd <= bus.rd_addr;
               end else if (!m_done) begin
                  m_busy <= 1; m_age <= 1; m_kill <= 0;
                  m_load <= bus.mem_signals[3];
                  m_sig <= bus.wb_signals; m_rd <= bus.rd_addr; m_alu <= bus.alu_result;
                  m_req <= 1; m_we <= bus.mem_signals[2];
                  m_addr  <= bus.mem_signals[1] ? bus.rdst_val : bus.rsrc_val;
                  m_wdata <= bus.mem_signals[0] ? bus.alu_result : bus.rsrc_val;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("stall", bus.stall, e_stall);
         chk("dm_req", bus.dm_req, m_req);
         chk("mem_err", bus.mem_err, e_err);
         chk("wb_valid", bus.wb_valid, e_wbv);
         if (m_req) begin
            chk("dm_we", bus.dm_we, m_we);
            chk("dm_addr", bus.dm_addr, m_addr);
            chk("dm_wdata", bus.dm_wdata, m_wdata);
         end
         if (e_wbv) begin
            chk("wb_signals_out", bus.wb_signals_out, e_sig);
            chk("wb_alu_data", bus.wb_alu_data, e_alu);
            chk("wb_rd", bus.wb_rd, e_rd);
            chk("wb_mem_data", bus.wb_mem_data, e_mdata);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic iv, input logic [3:0] ms, input logic [2:0] ws,
                        input logic [15:0] alu, input logic [15:0] rs, input logic [15:0] rdv,
                        input logic [2:0] rda);
      bus.in_valid    = iv;
      bus.mem_signals = ms;
      bus.wb_signals  = ws;
      bus.alu_result  = alu;
      bus.rsrc_val    = rs;
      bus.rdst_val    = rdv;
      bus.rd_addr     = rda;
   endtask

   task automatic bubble();
      drive(1'b0, 4'b0000, 3'b000, 16'h0, 16'h0, 16'h0, 3'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got hang, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nreq, nerr, nwbv;
      bit rel;
      bubble();
      bus.flush    = 1'b0;
      bus.dm_ack   = 1'b0;
      bus.dm_rdata = '0;
      #1 rst_n = 1'b0;
      chk_en = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_stall", bus.stall, 0);
      chk("rst_dm_req", bus.dm_req, 0);
      chk("rst_wb_valid", bus.wb_valid, 0);
      chk("rst_mem_err", bus.mem_err, 0);
      chk("rst_dm_addr", bus.dm_addr, 0);
      chk("rst_wb_alu", bus.wb_alu_data, 0);
      #2 rst_n = 1'b1;

      // 1: ADD pass-through
      step(); drive(1'b1, 4'b0000, 3'b101, 16'h1234, 16'h0011, 16'h0022, 3'd3);
      @(negedge clk); chk("t1_stall", bus.stall, 0);
      step(); bubble();
      @(negedge clk);
      chk("t1_wb_valid", bus.wb_valid, 1);
      chk("t1_wb_alu", bus.wb_alu_data, 16'h1234);
      chk("t1_wb_rd", bus.wb_rd, 3);
      chk("t1_model_alu", e_alu, 16'h1234);

      // 2: load, ack on the second BUSY cycle
      step(); drive(1'b1, 4'b1000, 3'b100, 16'h0, 16'h0040, 16'h0, 3'd2);
      @(negedge clk); chk("t2_stall_c0", bus.stall, 1); chk("t2_req_c0", bus.dm_req, 0);
      step();
      @(negedge clk);
      chk("t2_req", bus.dm_req, 1); chk("t2_we", bus.dm_we, 0);
      chk("t2_addr", bus.dm_addr, 16'h0040); chk("t2_stall_c1", bus.stall, 1);
      step(); bus.dm_ack = 1'b1; bus.dm_rdata = 16'hBEEF;
      @(negedge clk); chk("t2_stall_c2", bus.stall, 1);
      step(); bus.dm_ack = 1'b0; bus.dm_rdata = 16'h0;
      @(negedge clk);
      chk("t2_wb_valid", bus.wb_valid, 1); chk("t2_mdata", bus.wb_mem_data, 16'hBEEF);
      chk("t2_stall_done", bus.stall, 0); chk("t2_req_done", bus.dm_req, 0);
      chk("t2_wb_rd", bus.wb_rd, 2); chk("t2_model_mdata", e_mdata, 16'hBEEF);
      step(); bubble();
      @(negedge clk); chk("t2_wb_valid_after", bus.wb_valid, 0);

      // 3: store, immediate ack
      step(); drive(1'b1, 4'b0110, 3'b000, 16'h7777, 16'h00AA, 16'h0080, 3'd5);
      @(negedge clk); chk("t3_stall_c0", bus.stall, 1);
      step(); bus.dm_ack = 1'b1;
      @(negedge clk);
      chk("t3_req", bus.dm_req, 1); chk("t3_we", bus.dm_we, 1);
      chk("t3_addr", bus.dm_addr, 16'h0080); chk("t3_wdata", bus.dm_wdata, 16'h00AA);
      step(); bus.dm_ack = 1'b0;
      @(negedge clk);
      chk("t3_wb_valid", bus.wb_valid, 1); chk("t3_regwrite", bus.wb_signals_out[2], 0);
      step(); bubble();

      // 4: load that never acks
      step(); drive(1'b1, 4'b1000, 3'b100, 16'h0, 16'h0123, 16'h0, 3'd1);
      nreq = 0; nerr = 0; nwbv = 0; rel = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (rel) bubble();
         @(negedge clk);
         nreq += int'(bus.dm_req);
         nerr += int'(bus.mem_err);
         nwbv += int'(bus.wb_valid);
         if (!rel && !bus.stall) begin
            rel = 1;
            chk("t4_req_at_release", bus.dm_req, 0);
            chk("t4_err_at_release", bus.mem_err, 1);
         end
      end
      chk("t4_req_cycles", nreq, 4);
      chk("t4_err_pulses", nerr, 1);
      chk("t4_wb_valid_cnt", nwbv, 0);
      chk("t4_released", rel, 1);

      // 5: flush during BUSY, then ack; result discarded
      step(); drive(1'b1, 4'b1000, 3'b100, 16'h0, 16'h0200, 16'h0, 3'd4);
      @(negedge clk); chk("t5_stall_c0", bus.stall, 1);
      step(); bus.flush = 1'b1;
      @(negedge clk); chk("t5_stall_flush", bus.stall, 1);
      step(); bus.flush = 1'b0; bus.dm_ack = 1'b1; bus.dm_rdata = 16'hDEAD;
      @(negedge clk); chk("t5_stall_ack", bus.stall, 1); chk("t5_wbv_ack", bus.wb_valid, 0);
      step(); bus.dm_ack = 1'b0;
      @(negedge clk);
      chk("t5_wbv_done", bus.wb_valid, 0); chk("t5_stall_done", bus.stall, 0);
      chk("t5_mdata_kept", bus.wb_mem_data, 16'hBEEF);
      step(); drive(1'b1, 4'b0000, 3'b101, 16'h5555, 16'h0, 16'h0, 3'd6);
      @(negedge clk); chk("t5_add_stall", bus.stall, 0);
      step(); bubble();
      @(negedge clk);
      chk("t5_add_wbv", bus.wb_valid, 1); chk("t5_add_alu", bus.wb_alu_data, 16'h5555);
      chk("t5_add_rd", bus.wb_rd, 6);

      // 6: reset mid-transaction, then an illegal bundle
      step(); drive(1'b1, 4'b1000, 3'b100, 16'h0, 16'h0300, 16'h0, 3'd7);
      step();
      @(negedge clk); chk("t6_req_before", bus.dm_req, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_rst_req", bus.dm_req, 0);
      chk("t6_rst_stall", bus.stall, 0);
      chk("t6_rst_wbv", bus.wb_valid, 0);
      step(); drive(1'b1, 4'b1100, 3'b101, 16'h0ABC, 16'h0, 16'h0, 3'd3);
      @(negedge clk); #1 rst_n = 1'b1;
      #1 chk("t6_illegal_stall", bus.stall, 0);
      step(); bubble();
      @(negedge clk);
      chk("t6_err", bus.mem_err, 1); chk("t6_wbv", bus.wb_valid, 1);
      chk("t6_sig", bus.wb_signals_out, 3'b001); chk("t6_req", bus.dm_req, 0);
      step();
      @(negedge clk); chk("t6_err_pulse", bus.mem_err, 0); chk("t6_req_after", bus.dm_req, 0);
      step();
      @(negedge clk);
      chk_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
